// File: rtl/fdc_timer_sched.sv
// fdc_timer_sched: four-channel 8-bit countdown timer scheduler for the
// floppy CPU, clocked down by one shared prescaler tick (100 Hz nominal).
//
// Ports:
//   clk      master clock, all state on its rising edge
//   reset_n  asynchronous active-low reset
//   addr     register select (0-3 CNTi, 4 STATUS, 5 MASK, 6 MODE, 7 rsvd)
//   di       write data
//   wren     write strobe, one cycle per access
//   rden     read strobe, one cycle per access
//   q        registered read data, one cycle after rden
//   irq      level interrupt, |(status & mask)
//   tick     one-cycle pulse marking each prescaler rollover
module fdc_timer_sched #(
    parameter int MCLKFREQ = 24000000,
    parameter int TICKHZ   = 100,
    parameter int PRESCALE = MCLKFREQ / TICKHZ
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] addr,
    input  logic [7:0] di,
    input  logic       wren,
    input  logic       rden,
    output logic [7:0] q,
    output logic       irq,
    output logic       tick
);

    localparam logic [17:0] PS_LOAD = 18'(PRESCALE - 1);

    logic [17:0] psc;
    logic [7:0]  cnt [4];
    logic [7:0]  rld [4];
    logic [3:0]  status;
    logic [3:0]  mask;
    logic [3:0]  mode;

    logic        tk;
    logic [3:0]  wr_cnt;
    logic        wr_sta;
    logic        wr_msk;
    logic        wr_mod;
    logic        ps_restart;
    logic [3:0]  set;
    logic [7:0]  rdata;

    // Internal tick strobe: the cycle whose edge updates the channels.
    // The tick output is its registered copy, so it is high in the cycle
    // the updated counts and flags become visible.
    assign tk = (psc == 18'd0);

    always_comb begin
        wr_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            wr_cnt[i] = wren && (addr == 3'(i));
        end
        wr_sta     = wren && (addr == 3'd4);
        wr_msk     = wren && (addr == 3'd5);
        wr_mod     = wren && (addr == 3'd6);
        ps_restart = wr_mod && di[7];
    end

    // A CNTi write in a tick cycle takes priority, so it suppresses the flag.
    always_comb begin
        set = '0;
        for (int i = 0; i < 4; i++) begin
            set[i] = tk && !wr_cnt[i] && (cnt[i] == 8'd1);
        end
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            (addr[2] == 1'b0): rdata = cnt[addr[1:0]];
            (addr == 3'd4):    rdata = {4'h0, status};
            (addr == 3'd5):    rdata = {4'h0, mask};
            (addr == 3'd6):    rdata = {4'h0, mode};
            default:           rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psc  <= PS_LOAD;
            tick <= 1'b0;
        end else begin
            tick <= tk;
            if (tk || ps_restart) begin
                psc <= PS_LOAD;
            end else begin
                psc <= psc - 18'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
                rld[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_cnt[i]) begin
                    cnt[i] <= di;
                    rld[i] <= di;
                end else if (tk && cnt[i] != 8'd0) begin
                    if (cnt[i] == 8'd1) begin
                        cnt[i] <= (mode[i] && rld[i] != 8'd0) ?
                                  rld[i] : 8'd0;
                    end else begin
                        cnt[i] <= cnt[i] - 8'd1;
                    end
                end
            end
        end
    end

    // Clear is applied before set so a same-cycle expiry keeps its flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status <= '0;
            mask   <= '0;
            mode   <= '0;
        end else begin
            status <= (status & ~(wr_sta ? di[3:0] : 4'h0)) | set;
            if (wr_msk) begin
                mask <= di[3:0];
            end
            if (wr_mod) begin
                mode <= di[3:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (rden) begin
            q <= rdata;
        end
    end

    assign irq = |(status & mask);

endmodule

// File: tb/tb_fdc_timer_sched.sv
// tb_fdc_timer_sched: directed bench for fdc_timer_sched with PRESCALE=4,
// checked every cycle against an edge-scheduled behavioural model.
module tb_fdc_timer_sched;

    localparam int P = 4;

    logic       clk;
    logic       reset_n;
    logic [2:0] addr;
    logic [7:0] di;
    logic       wren;
    logic       rden;
    logic [7:0] q;
    logic       irq;
    logic       tick;

    int checks = 0;
    int errors = 0;

    fdc_timer_sched #(.PRESCALE(P)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr),
        .di      (di),
        .wren    (wren),
        .rden    (rden),
        .q       (q),
        .irq     (irq),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: ticks are scheduled as absolute edge numbers since the last
    // reset release or prescaler restart; channels follow the expiry rules.
    logic [7:0] m_cnt [4];
    logic [7:0] m_rld [4];
    logic [3:0] m_sta;
    logic [3:0] m_msk;
    logic [3:0] m_mod;
    logic [7:0] m_q;
    logic       m_tick;
    int         ecount;
    int         next_tk;

    function automatic logic [7:0] regval(input logic [2:0] a);
        if (a < 3'd4) return m_cnt[a[1:0]];
        if (a == 3'd4) return {4'h0, m_sta};
        if (a == 3'd5) return {4'h0, m_msk};
        if (a == 3'd6) return {4'h0, m_mod};
        return 8'h00;
    endfunction

    task automatic model_step();
        int         e;
        bit         tk;
        int         ntk;
        logic [7:0] n_cnt [4];
        logic [7:0] n_rld [4];
        logic [3:0] flags;
        logic [3:0] clr;
        e     = ecount + 1;
        tk    = (e == next_tk);
        ntk   = next_tk;
        if (tk) ntk = e + P;
        if (wren && addr == 3'd6 && di[7]) ntk = e + P;
        n_cnt = m_cnt;
        n_rld = m_rld;
        flags = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (wren && addr == 3'(i)) begin
                n_cnt[i] = di;
                n_rld[i] = di;
            end else if (tk && m_cnt[i] > 8'd1) begin
                n_cnt[i] = m_cnt[i] - 8'd1;
            end else if (tk && m_cnt[i] == 8'd1) begin
                flags[i] = 1'b1;
                n_cnt[i] = (m_mod[i] && m_rld[i] != 0) ? m_rld[i] : 8'd0;
            end
        end
        clr = (wren && addr == 3'd4) ? di[3:0] : 4'h0;
        if (rden) m_q <= regval(addr);
        if (wren && addr == 3'd5) m_msk <= di[3:0];
        if (wren && addr == 3'd6) m_mod <= di[3:0];
        m_sta   <= (m_sta & ~clr) | flags;
        m_cnt   <= n_cnt;
        m_rld   <= n_rld;
        m_tick  <= tk;
        ecount  <= e;
        next_tk <= ntk;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] <= '0;
                m_rld[i] <= '0;
            end
            m_sta   <= '0;
            m_msk   <= '0;
            m_mod   <= '0;
            m_q     <= '0;
            m_tick  <= 1'b0;
            ecount  <= 0;
            next_tk <= P;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        chk("q", q, m_q);
        chk("irq", irq, |(m_sta & m_msk));
        chk("tick", tick, m_tick);
    end

    task automatic wr(input int a, input int d);
        addr = 3'(a);
        di   = 8'(d);
        wren = 1'b1;
        @(negedge clk);
        wren = 1'b0;
    endtask

    task automatic rd(input int a, input int exp, input string nm);
        addr = 3'(a);
        rden = 1'b1;
        @(negedge clk);
        rden = 1'b0;
        chk(nm, q, exp);
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(negedge clk);
            seen = tick;
        end
        chk("tick_timeout", seen, 1);
    endtask

    initial begin
        reset_n = 1'b0;
        addr    = '0;
        di      = '0;
        wren    = 1'b0;
        rden    = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Idle: tick on edges 4, 8, 12 after release.
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("idle_tick", tick, (k % 4 == 0) ? 1 : 0);
        end
        chk("idle_irq", irq, 0);
        for (int a = 0; a < 8; a++) rd(a, 0, "idle_reg");

        // One-shot channel 0.
        wr(5, 8'h01);
        wr(6, 8'h00);
        wr(0, 3);
        wait_tick();
        rd(0, 2, "c0_2");
        wait_tick();
        rd(0, 1, "c0_1");
        wait_tick();
        chk("c0_irq", irq, 1);
        rd(4, 8'h01, "c0_sta");
        rd(0, 0, "c0_0");
        wait_tick();
        rd(0, 0, "c0_hold");
        wr(4, 8'h01);
        chk("c0_irq_clr", irq, 0);
        wait_tick();
        rd(4, 0, "c0_noflag");

        // Periodic channel 1.
        wr(5, 8'h02);
        wr(6, 8'h02);
        wr(1, 2);
        wait_tick();
        rd(1, 1, "c1_1");
        wait_tick();
        rd(4, 8'h02, "c1_sta");
        chk("c1_irq", irq, 1);
        rd(1, 2, "c1_reload");
        wr(4, 8'h02);
        chk("c1_irq_clr", irq, 0);
        wait_tick();
        rd(1, 1, "c1_1b");
        wait_tick();
        rd(4, 8'h02, "c1_sta2");
        wr(1, 0);
        wr(4, 8'h02);
        rd(1, 0, "c1_stop");
        wait_tick();
        wait_tick();
        rd(4, 0, "c1_noflag");

        // CNT2 write lands on the tick edge, then stop mid-count.
        wr(5, 8'h07);
        wait_tick();
        repeat (3) @(negedge clk);
        wr(2, 5);
        chk("c2_tick_cyc", tick, 1);
        rd(2, 5, "c2_win");
        wait_tick();
        rd(2, 4, "c2_dec");
        wr(2, 0);
        rd(2, 0, "c2_stop");
        wait_tick();
        wait_tick();
        rd(4, 0, "c2_noflag");
        chk("c2_irq", irq, 0);

        // W1C collides with channel 0 expiry: set wins.
        wr(0, 2);
        wait_tick();
        repeat (3) @(negedge clk);
        wr(4, 8'h01);
        rd(4, 8'h01, "w1c_set_wins");
        chk("w1c_irq", irq, 1);
        wr(5, 8'h00);
        chk("mask_off_irq", irq, 0);
        rd(4, 8'h01, "mask_off_sta");

        // Prescaler restart two edges before a tick.
        wait_tick();
        @(negedge clk);
        wr(6, 8'h80);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("restart_gap", tick, 0);
        end
        @(negedge clk);
        chk("restart_tick", tick, 1);
        rd(6, 0, "mode_rd");

        // Asynchronous reset mid-count.
        wr(5, 8'h0F);
        wr(0, 9);
        wr(6, 8'h0F);
        wr(1, 7);
        chk("pre_rst_irq", irq, 1);
        rd(5, 8'h0F, "pre_rst_q");
        #2 reset_n = 1'b0;
        #1;
        chk("rst_q", q, 0);
        chk("rst_irq", irq, 0);
        chk("rst_tick", tick, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_phase", tick, 0);
        end
        @(negedge clk);
        chk("rst_first_tick", tick, 1);
        for (int a = 0; a < 8; a++) rd(a, 0, "rst_reg");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/fdc_timer_sched.md
Name: fdc_timer_sched

Overview:
- Four-channel countdown timer scheduler for the floppy CPU. It replaces the single 100 Hz tick-tock timer peripheral.
- One shared prescaler generates the 100 Hz tick. All four 8-bit channels decrement on that tick.
- Each channel supports one-shot or periodic (auto-reload) mode. Expiry flags are write-1-to-clear, and a maskable IRQ is raised on expiry.
- Sits on the floppy CPU I/O bus. Used for motor-off, head-settle and step-rate timeouts.

Parameters:
- MCLKFREQ, 24000000, master clock frequency in Hz.
- TICKHZ, 100, tick rate in Hz.
- PRESCALE, MCLKFREQ/TICKHZ, clocks per tick; must be ≥2 and ≤2^18. Benches override it to a small value.

Ports:
- clk  in  1  master clock; all state on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- addr  in  3  register select.
- di  in  8  write data.
- wren  in  1  write strobe, one cycle per access.
- rden  in  1  read strobe, one cycle per access.
- q  out  8  registered read data.
- irq  out  1  interrupt request, level, active-high.
- tick  out  1  one-cycle pulse at each prescaler rollover.

Behaviour:
- Reset (async, reset_n=0):
  - cnt[0..3], rld[0..3], status, mask and mode all = 0.
  - q=0, tick=0, irq=0.
  - Prescaler = PRESCALE-1.
- Register map:
  - 0-3: CNTi.
    - Write: cnt[i]<=di and rld[i]<=di.
    - Read: current cnt[i].
  - 4: STATUS. Bits 3:0 are the expiry flags. Write 1 to clear; writing 0 leaves a bit unchanged. Bits 7:4 read 0.
  - 5: MASK. Bits 3:0 are R/W IRQ enables. Bits 7:4 read 0.
  - 6: MODE.
    - Bits 3:0: 1 = periodic, 0 = one-shot; R/W.
    - Bit 7: prescaler restart. Write-only, self-clearing, reads 0.
  - 7: reserved. Writes ignored, reads 0.
- Prescaler:
  - 18-bit down counter.
  - At 0: reloads PRESCALE-1 and asserts tick for exactly that cycle. Otherwise decrements.
  - Tick period is exactly PRESCALE clocks; the first tick comes PRESCALE clocks after reset release.
  - A MODE write with di[7]=1 loads PRESCALE-1. If the prescaler was at 0 that cycle, tick still fires.
- Channel update on a tick, per channel i, with no write to CNTi in that cycle:
  - cnt=0: hold, no flag (idle).
  - cnt>1: cnt<=cnt-1.
  - cnt=1: set status[i].
    - Then, if mode[i]=1 and rld[i]≠0: cnt<=rld[i].
    - Otherwise cnt<=0.
- Simultaneous events:
  - A write to CNTi in a tick cycle wins for that channel: cnt<=di, no decrement, no flag.
  - Writing 0 stops the channel without setting a flag.
  - A STATUS W1C in the same cycle as a flag set: set wins, and the bit stays 1.
  - wren and rden in the same cycle: both take effect. q returns the pre-write value.
- Read timing:
  - On rden, q <= the selected register value as of that edge (1-cycle latency).
  - With rden=0, q holds its value.
- irq = |(status & mask), taken combinationally from registered state. It rises in the same cycle the flag becomes visible.
- Counter width: cnt is 8-bit, so the maximum delay is 255 ticks (2.55 s at 100 Hz). Counters never wrap below 0.
- Reset mid-operation: all state returns to reset values immediately, including any pending flags and the prescaler phase.

Test Plan (PRESCALE=4):
- Reset release, no writes -> tick pulses on cycles 4, 8, 12 after release; q=0, irq=0, all registers read 0.
- Write CNT0=3, MASK=0x01, MODE=0 -> cnt0 reads 2, 1, 0 on successive ticks. status=0x01 and irq=1 on the third tick. CNT0 then stays 0 with no further flags.
- MODE=0x02, CNT1=2 -> status bit1 set every 2 ticks. cnt1 sequence 2,1,2,1,... Write STATUS=0x02 -> bit clears and irq drops (mask bit1 set).
- Write CNT2=5 in the exact tick cycle -> cnt2 reads 5 after that tick, not 4. Write CNT2=0 mid-count -> stops, no flag.
- Issue STATUS=0x01 W1C in the cycle cnt0 goes 1->0 -> status bit0 remains 1. Set MASK=0 -> irq=0 while status=0x01.
- Write MODE=0x80 two clocks before the expected tick -> next tick arrives 4 clocks after the write. MODE reads 0x00. Assert reset_n=0 mid-count -> all registers 0 asynchronously.
